// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, state encodings and the parity helper.
// The transmitter uses the same encodings, so a debug bus reads the same on both sides.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100
    } uart_state_e;

    // Even parity check: 1 when the data bits plus the parity bit hold an odd number of ones.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. It resets to 1 because
// the line idles high, so no false start bit is seen when reset is released.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the raw line into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, stop.
// Bits are sampled at mid-bit, counted from the synchronized falling edge of the start bit.
//
// Handshake: rx_valid rises the cycle after the stop-bit sample and stays high until the
// consumer pulses rx_ack while rx_valid is high; rx_valid then drops on the next cycle.
// rx_ack while rx_valid is low is ignored. A new byte that completes while rx_valid is
// still high and unacknowledged replaces rx_data and sets the sticky overrun flag; if it
// completes in the same cycle as rx_ack, the new byte is taken with no overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [2:0]        state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              prev_q;
    logic              rx_s;
    logic              tick;
    logic [CNT_W-1:0]  cnt_wrap;
    logic              load;

    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    assign tick     = (cnt_q == CNT_LAST);
    assign cnt_wrap = tick ? '0 : cnt_q + 1'b1;

    // State register, bit timing, shift register and output holding registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            prev_q       <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            prev_q       <= rx_s;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame sequencing: next state, bit timing and data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                // Only a high-to-low edge starts a frame; a line stuck low does not.
                if (prev_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    // Restart the counter here so later samples land at mid-bit.
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    perr_d  = parity_mismatch(shift_q, rx_s);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_wrap;
                if (tick) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Delivery to the consumer: byte load, valid/ack handshake and sticky overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (load) begin
            rx_data_d    = shift_q;
            parity_err_d = PARITY_EN ? perr_q : 1'b0;
            frame_err_d  = !rx_s;
            rx_valid_d   = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign state_o    = state_q;

endmodule
